// File: rtl/nand_checker_pkg.sv
// Shared definitions for the NAND gate checker: FSM encoding, vector count,
// failed-sweep saturation value and the expected-response rule.
package nand_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int         VEC_COUNT    = 4;
    localparam logic [1:0] LAST_VEC     = 2'(VEC_COUNT - 1);
    localparam logic [3:0] FAIL_CNT_MAX = 4'd15;

    // A healthy NAND returns NOT(A AND B); A is index bit 0, B is index bit 1.
    function automatic logic nand_expect(input logic [1:0] idx);
        return ~(idx[0] & idx[1]);
    endfunction

endpackage

// File: rtl/nand_checker_if.sv
// Bundle of the Tiny Tapeout pin groups. The master side drives the pins
// into the checker, and the slave side is the checker itself.
interface nand_checker_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input  uo_out, uio_out, uio_oe);
    modport slave  (input  ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);

endinterface

// File: rtl/nand_checker_core.sv
// Sweep engine. It drives the four A/B vectors, waits SETTLE_CYCLES for the
// gate under test, samples Y and reports the per-vector fail mask, the pass
// flag and a saturating count of failed sweeps.
module nand_checker_core
    import nand_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4      // legal range 3..255
) (
    input  logic           clk,
    input  logic           rst_n,
    nand_checker_if.slave  bus
);

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_next;
    logic [1:0] idx, idx_next;
    logic [7:0] cnt, cnt_next;
    logic [3:0] work_mask, work_mask_next;
    logic [3:0] rep_mask, rep_mask_next;
    logic [3:0] fail_cnt, fail_cnt_next;
    logic       pass, pass_next;
    logic       a, a_next, b, b_next;
    logic       start_s, y_s, loop_s, start_prev;
    logic       start_edge, restart, busy;
    logic       unused;

    sync2 u_sync_start (.clk(clk), .rst_n(rst_n), .d(bus.ui_in[0]), .q(start_s));
    sync2 u_sync_y     (.clk(clk), .rst_n(rst_n), .d(bus.ui_in[1]), .q(y_s));
    sync2 u_sync_loop  (.clk(clk), .rst_n(rst_n), .d(bus.ui_in[2]), .q(loop_s));

    assign start_edge = start_s & ~start_prev;
    assign busy       = (state == SETTLE) || (state == SAMPLE);
    assign unused     = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:3]};

    // Next-state and next-value logic for the sweep FSM.
    // NOTE: every variable gets a default first, so no branch can infer a latch.
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        cnt_next       = cnt;
        work_mask_next = work_mask;
        rep_mask_next  = rep_mask;
        fail_cnt_next  = fail_cnt;
        pass_next      = pass;
        restart        = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    restart   = 1'b1;
                    pass_next = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) state_next = SAMPLE;
                else             cnt_next   = cnt - 8'd1;
            end
            SAMPLE: begin
                work_mask_next[idx] = (y_s != nand_expect(idx));
                if (idx == LAST_VEC) begin
                    state_next    = DONE;
                    rep_mask_next = work_mask_next;
                    pass_next     = (work_mask_next == 4'd0);
                    if (work_mask_next != 4'd0 && fail_cnt != FAIL_CNT_MAX)
                        fail_cnt_next = fail_cnt + 4'd1;
                end else begin
                    idx_next   = idx + 2'd1;
                    cnt_next   = RELOAD;
                    state_next = SETTLE;
                end
            end
            DONE: begin
                // Loop mode restarts after one DONE cycle and keeps the report.
                if (loop_s) begin
                    restart = 1'b1;
                end else if (start_edge) begin
                    restart   = 1'b1;
                    pass_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        if (restart) begin
            state_next     = SETTLE;
            idx_next       = 2'd0;
            work_mask_next = 4'd0;
            cnt_next       = RELOAD;
        end

        // A/B follow the vector index only while a vector is applied.
        a_next = (state_next == SETTLE || state_next == SAMPLE) ? idx_next[0] : 1'b0;
        b_next = (state_next == SETTLE || state_next == SAMPLE) ? idx_next[1] : 1'b0;
    end

    // State and datapath registers, all cleared by reset.
    // NOTE: masks and counters sit in the async reset too, so a reset abandons a sweep cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= 8'd0;
            work_mask  <= 4'd0;
            rep_mask   <= 4'd0;
            fail_cnt   <= 4'd0;
            pass       <= 1'b0;
            a          <= 1'b0;
            b          <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            cnt        <= cnt_next;
            work_mask  <= work_mask_next;
            rep_mask   <= rep_mask_next;
            fail_cnt   <= fail_cnt_next;
            pass       <= pass_next;
            a          <= a_next;
            b          <= b_next;
            start_prev <= start_s;
        end
    end

    assign bus.uo_out  = {1'b0, idx, pass, (state == DONE), busy, b, a};
    assign bus.uio_out = {fail_cnt, rep_mask};
    assign bus.uio_oe  = 8'hFF;

endmodule

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the input through two flops to settle metastability.
    // NOTE: sequential state uses non-blocking assignments so both flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_um_peter_william_nand_checker.sv
// Tiny Tapeout top: maps the flat pin groups onto the checker interface.
module tt_um_peter_william_nand_checker #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    nand_checker_if bus ();

    assign bus.ena    = ena;
    assign bus.ui_in  = ui_in;
    assign bus.uio_in = uio_in;
    assign uo_out     = bus.uo_out;
    assign uio_out    = bus.uio_out;
    assign uio_oe     = bus.uio_oe;

    nand_checker_core #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

endmodule

// File: tb/tb_tt_um_peter_william_nand_checker.sv
// Testbench for the NAND checker: a behavioural gate model closes the loop
// and a reference model predicts the fail mask, pass flag and sweep count.
module tb_tt_um_peter_william_nand_checker;

    localparam int SETTLE    = 4;
    localparam int VEC_CYC   = SETTLE + 1;
    localparam int SWEEP_CYC = 4 * VEC_CYC;
    localparam int M_GOOD    = 0;
    localparam int M_STUCK1  = 1;
    localparam int M_STUCK0  = 2;
    localparam int M_FLIP    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_in = 1'b0;
    logic       loop_in = 1'b0;
    logic       y_gate;
    logic [3:0] flip_mask = 4'd0;
    int         gate_mode = M_GOOD;
    int         checks = 0;
    int         errors = 0;
    int         model_cnt = 0;
    int         ref_latency = 0;

    nand_checker_if bus ();

    always #5 clk = ~clk;

    // Gate under test: a NAND, optionally stuck or with per-vector flips.
    always_comb begin
        y_gate = ~(bus.uo_out[0] & bus.uo_out[1]);
        case (gate_mode)
            M_STUCK1: y_gate = 1'b1;
            M_STUCK0: y_gate = 1'b0;
            M_FLIP:   y_gate = y_gate ^ flip_mask[{bus.uo_out[1], bus.uo_out[0]}];
            default:  ;
        endcase
    end

    assign bus.ui_in  = {5'b0, loop_in, y_gate, start_in};
    assign bus.ena    = 1'b1;
    assign bus.uio_in = 8'h00;

    tt_um_peter_william_nand_checker #(.SETTLE_CYCLES(SETTLE)) dut (
        .ui_in   (bus.ui_in),
        .uo_out  (bus.uo_out),
        .uio_in  (bus.uio_in),
        .uio_out (bus.uio_out),
        .uio_oe  (bus.uio_oe),
        .ena     (bus.ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    // Reference: which vectors a gate of the given kind would get wrong.
    function automatic logic [3:0] model_mask(input int mode, input logic [3:0] flip);
        logic [3:0] m;
        logic       a, b, good, y;
        m = 4'd0;
        for (int v = 0; v < 4; v++) begin
            a    = v[0];
            b    = v[1];
            good = !(a && b);
            case (mode)
                M_STUCK1: y = 1'b1;
                M_STUCK0: y = 1'b0;
                M_FLIP:   y = good ^ flip[v];
                default:  y = good;
            endcase
            m[v] = (y != good);
        end
        return m;
    endfunction

    task automatic pulse_start_wait_busy(output int waited);
        waited   = 0;
        start_in = 1'b1;
        while (waited < 16) begin
            @(negedge clk);
            waited++;
            if (waited >= 3) start_in = 1'b0;
            if (bus.uo_out[2]) break;
        end
        start_in = 1'b0;
        checks++;
        if (bus.uo_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, required 1", bus.uo_out[2], waited);
        end
    endtask

    // Checks every busy cycle's A/B/index, then the DONE report.
    task automatic check_sweep(input logic [3:0] exp_mask, input bit extra_start);
        logic [6:0] exp_bits, got_bits;
        logic [5:0] exp_done, got_done;
        logic [1:0] v;
        for (int k = 0; k < SWEEP_CYC; k++) begin
            if (k > 0) @(negedge clk);
            if (extra_start && k == 4) start_in = 1'b1;
            if (extra_start && k == 8) start_in = 1'b0;
            v        = 2'(k / VEC_CYC);
            exp_bits = {1'b0, v, 1'b0, 1'b1, v[1], v[0]};
            got_bits = {bus.uo_out[7:5], bus.uo_out[3:0]};
            checks++;
            if (got_bits !== exp_bits) begin
                errors++;
                $display("FAIL sweep_cycle_%0d: {uo[7:5],uo[3:0]}=%b, required %b", k, got_bits, exp_bits);
            end
        end
        @(negedge clk);
        if (exp_mask != 4'd0 && model_cnt < 15) model_cnt++;
        exp_done = {1'b0, (exp_mask == 4'd0), 1'b1, 1'b0, 2'b00};
        got_done = {bus.uo_out[7], bus.uo_out[4:0]};
        checks++;
        if (got_done !== exp_done) begin
            errors++;
            $display("FAIL done_flags: {uo[7],uo[4:0]}=%b, required %b", got_done, exp_done);
        end
        checks++;
        if (bus.uio_out !== {4'(model_cnt), exp_mask}) begin
            errors++;
            $display("FAIL done_report: uio_out=%h, required %h", bus.uio_out, {4'(model_cnt), exp_mask});
        end
    endtask

    task automatic run_sweep(input int mode, input logic [3:0] flip, input bit extra_start,
                             output int latency);
        int w;
        gate_mode = mode;
        flip_mask = flip;
        pulse_start_wait_busy(w);
        check_sweep(model_mask(mode, flip), extra_start);
        latency = w + SWEEP_CYC;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: uo=%h uio=%h, required 00 00", bus.uo_out, bus.uio_out);
        end
        checks++;
        if (bus.uio_oe !== 8'hFF) begin
            errors++;
            $display("FAIL uio_oe: got %h, required ff", bus.uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset: uo=%h, required 00", bus.uo_out);
        end
    endtask

    task automatic test_ideal();
        run_sweep(M_GOOD, 4'd0, 1'b0, ref_latency);
    endtask

    task automatic test_stuck();
        int lat;
        run_sweep(M_STUCK1, 4'd0, 1'b0, lat);
        run_sweep(M_STUCK0, 4'd0, 1'b0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        run_sweep(M_GOOD, 4'd0, 1'b1, lat);
        checks++;
        if (lat != ref_latency) begin
            errors++;
            $display("FAIL busy_start_latency: %0d cycles, required %0d", lat, ref_latency);
        end
    endtask

    task automatic test_done_hold();
        logic [7:0] uio_before;
        uio_before = bus.uio_out;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.uo_out[3] !== 1'b1 || bus.uo_out[2] !== 1'b0 || bus.uio_out !== uio_before) begin
            errors++;
            $display("FAIL done_hold: done=%b busy=%b uio=%h, required 1 0 %h",
                     bus.uo_out[3], bus.uo_out[2], bus.uio_out, uio_before);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [3:0] f;
        for (int i = 0; i < 6; i++) begin
            f = 4'($urandom_range(0, 15));
            run_sweep(M_FLIP, f, 1'b0, lat);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        gate_mode = M_GOOD;
        pulse_start_wait_busy(w);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_cnt = 0;
        checks++;
        if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: uo=%h uio=%h, required 00 00", bus.uo_out, bus.uio_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_idle: uo=%h uio=%h, required 00 00", bus.uo_out, bus.uio_out);
        end
        run_sweep(M_GOOD, 4'd0, 1'b0, w);
    endtask

    task automatic test_loop();
        int cycles;
        int waited;
        gate_mode = M_STUCK1;
        loop_in   = 1'b1;
        waited    = 0;
        while (waited < 8 && bus.uo_out[2] !== 1'b1) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.uo_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL loop_start: busy=%b, required 1", bus.uo_out[2]);
            loop_in = 1'b0;
            return;
        end
        for (int i = 0; i < 20; i++) begin
            cycles = 1;
            while (cycles <= 40) begin
                @(negedge clk);
                if (bus.uo_out[3]) break;
                cycles++;
            end
            checks++;
            if (cycles != SWEEP_CYC || bus.uo_out[3] !== 1'b1) begin
                errors++;
                $display("FAIL loop_sweep_%0d: %0d busy cycles done=%b, required %0d 1",
                         i, cycles, bus.uo_out[3], SWEEP_CYC);
                loop_in = 1'b0;
                return;
            end
            if (model_cnt < 15) model_cnt++;
            checks++;
            if (bus.uio_out !== {4'(model_cnt), 4'b1000} || bus.uo_out[4] !== 1'b0) begin
                errors++;
                $display("FAIL loop_report_%0d: uio=%h pass=%b, required %h 0",
                         i, bus.uio_out, bus.uo_out[4], {4'(model_cnt), 4'b1000});
            end
            if (i == 19) loop_in = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.uo_out[3] !== 1'b0 || bus.uo_out[2] !== 1'b1) begin
                errors++;
                $display("FAIL loop_done_pulse_%0d: done=%b busy=%b, required 0 1",
                         i, bus.uo_out[3], bus.uo_out[2]);
            end
        end
        cycles = 0;
        while (cycles < 40 && bus.uo_out[3] !== 1'b1) begin
            @(negedge clk);
            cycles++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.uo_out[3] !== 1'b1 || bus.uio_out !== 8'hF8) begin
            errors++;
            $display("FAIL loop_saturate_hold: done=%b uio=%h, required 1 f8", bus.uo_out[3], bus.uio_out);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_done_hold();
        test_stuck();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_loop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
